para_regs_bank: RTL

Parametrised fx-bus register bank for device-level configuration and status. It decodes the 6-bit device select in fx address bits [21:16] and exposes CFG_NUM byte-wide read/write configuration registers with per-register write strobes. It also exposes STA_NUM 16-bit status words with atomic two-byte reads, a saturating bad-address counter and an optional shadow/commit scheme. It replaces fixed per-block register files across the para/ctrl blocks on the fx bus.

---
 rtl/para_regs_pkg.sv | 25 ++
 rtl/para_regs_if.sv | 14 +
 rtl/para_sta_snap.sv | 62 ++++++
 rtl/para_regs_bank.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/para_regs_pkg.sv
// Shared constants and helpers for the para_regs_bank fx-bus register bank.
package para_regs_pkg;

  localparam logic [15:0] ADDR_ID     = 16'h0000;
  localparam logic [15:0] ADDR_VER    = 16'h0001;
  localparam logic [15:0] ADDR_ERR    = 16'h0002;
  localparam logic [15:0] ADDR_COMMIT = 16'h007F;

  localparam int DEVSEL_HI = 21;
  localparam int DEVSEL_LO = 16;

  function automatic logic [5:0] devsel(input logic [21:0] addr);
    return addr[DEVSEL_HI:DEVSEL_LO];
  endfunction

  function automatic logic [7:0] cfg_rst_val(input logic [15:0] base, input int idx);
    return base[7:0] + 8'(idx);
  endfunction

  function automatic logic ranges_overlap(input int a_lo, input int a_hi,
                                          input int b_lo, input int b_hi);
    return (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

endpackage

// File: rtl/para_regs_if.sv
// fx-bus access port: byte write channel, read request and registered read data.
interface para_regs_if;
  logic        fx_wr;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;

  modport master (output fx_wr, output fx_waddr, output fx_data,
                  output fx_rd, output fx_raddr, input fx_q);
  modport slave  (input fx_wr, input fx_waddr, input fx_data,
                  input fx_rd, input fx_raddr, output fx_q);
endinterface

// File: rtl/para_sta_snap.sv
// Status word decode with per-word high-byte hold so a low-then-high read pair is atomic.
module para_sta_snap
  import para_regs_pkg::*;
#(
  parameter int          STA_NUM  = 4,
  parameter logic [15:0] STA_BASE = 16'h0050
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   rd_sel_i,
  input  logic [15:0]            raddr_i,
  input  logic [16*STA_NUM-1:0]  sta_i,
  output logic                   hit_o,
  output logic [7:0]             rdata_o
);

  logic [7:0]         hold_q [STA_NUM];
  logic [7:0]         hold_d [STA_NUM];
  logic [STA_NUM-1:0] hv_q;
  logic [STA_NUM-1:0] hv_d;

  // Low-byte read snapshots the high byte; the matching high-byte read consumes it.
  always_comb begin
    hit_o   = 1'b0;
    rdata_o = 8'h00;
    hold_d  = hold_q;
    hv_d    = hv_q;
    for (int k = 0; k < STA_NUM; k++) begin
      if (raddr_i == STA_BASE + 16'(2 * k)) begin
        hit_o   = 1'b1;
        rdata_o = sta_i[16*k +: 8];
        if (rd_sel_i) begin
          hold_d[k] = sta_i[16*k+8 +: 8];
          hv_d[k]   = 1'b1;
        end else begin
          hold_d[k] = hold_q[k];
          hv_d[k]   = hv_q[k];
        end
      end else if (raddr_i == STA_BASE + 16'(2 * k + 1)) begin
        hit_o   = 1'b1;
        rdata_o = hv_q[k] ? hold_q[k] : sta_i[16*k+8 +: 8];
        hv_d[k] = rd_sel_i ? 1'b0 : hv_q[k];
      end else begin
        hv_d[k] = hv_q[k];
      end
    end
  end

  // Hold/valid state registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STA_NUM; k++) begin
        hold_q[k] <= 8'h00;
      end
      hv_q <= '0;
    end else begin
      hold_q <= hold_d;
      hv_q   <= hv_d;
    end
  end

endmodule

// File: rtl/para_regs_bank.sv
// Parametrised fx-bus config/status register bank.
// Optional shadow/commit scheme enabled by defining PARA_REGS_SHADOW_EN.
module para_regs_bank
  import para_regs_pkg::*;
#(
  parameter int          CFG_NUM  = 8,
  parameter logic [15:0] CFG_BASE = 16'h0080,
  parameter int          STA_NUM  = 4,
  parameter logic [15:0] STA_BASE = 16'h0050,
  parameter logic [7:0]  VERSION  = 8'h02
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [5:0]            dev_id,
  para_regs_if.slave            fx,
  output logic [8*CFG_NUM-1:0]  cfg_q,
  output logic [CFG_NUM-1:0]    cfg_wstb,
  input  logic [16*STA_NUM-1:0] sta_in,
  output logic [7:0]            err_cnt
);

  localparam int CFG_LO = int'(CFG_BASE);
  localparam int CFG_HI = CFG_LO + CFG_NUM - 1;
  localparam int STA_LO = int'(STA_BASE);
  localparam int STA_HI = STA_LO + 2 * STA_NUM - 1;
  localparam bit PARAM_BAD =
      (CFG_NUM < 1) || (CFG_NUM > 64) || (STA_NUM < 1) || (STA_NUM > 32) ||
      (CFG_HI > 65535) || (STA_HI > 65535) ||
      ranges_overlap(CFG_LO, CFG_HI, STA_LO, STA_HI) ||
      ranges_overlap(CFG_LO, CFG_HI, 0, 2) || ranges_overlap(STA_LO, STA_HI, 0, 2) ||
      ranges_overlap(CFG_LO, CFG_HI, 127, 127) || ranges_overlap(STA_LO, STA_HI, 127, 127);

  if (PARAM_BAD) begin : g_param_check
    $error("para_regs_bank: illegal CFG/STA parameters or overlapping address ranges");
  end

  logic        wr_sel_s;
  logic        rd_sel_s;
  logic [15:0] waddr_s;
  logic [15:0] raddr_s;

  assign wr_sel_s = fx.fx_wr & (devsel(fx.fx_waddr) == dev_id);
  assign rd_sel_s = fx.fx_rd & (devsel(fx.fx_raddr) == dev_id);
  assign waddr_s  = fx.fx_waddr[15:0];
  assign raddr_s  = fx.fx_raddr[15:0];

  logic [7:0]         cfg_q_q [CFG_NUM];
  logic [7:0]         cfg_q_d [CFG_NUM];
  logic [7:0]         view_s  [CFG_NUM];
  logic [CFG_NUM-1:0] wstb_q;
  logic [CFG_NUM-1:0] wstb_d;
  logic [7:0]         err_q;
  logic [7:0]         err_d;
  logic [7:0]         fx_q_q;
  logic [7:0]         fx_q_d;
  logic [CFG_NUM-1:0] cfg_whit_s;
  logic [CFG_NUM-1:0] cfg_rhit_s;
  logic [7:0]         cfg_rdata_s;
  logic               cfg_wr_s;
  logic               bad_wr_s;
  logic               sta_hit_s;
  logic [7:0]         sta_rdata_s;

  // Config address decode for both ports and read-side byte select.
  always_comb begin
    cfg_rdata_s = 8'h00;
    for (int i = 0; i < CFG_NUM; i++) begin
      cfg_whit_s[i] = (waddr_s == CFG_BASE + 16'(i));
      cfg_rhit_s[i] = (raddr_s == CFG_BASE + 16'(i));
      cfg_rdata_s   = cfg_rdata_s | (cfg_rhit_s[i] ? view_s[i] : 8'h00);
    end
  end

  assign cfg_wr_s = wr_sel_s & (|cfg_whit_s);

`ifdef PARA_REGS_SHADOW_EN
  logic [7:0]         shd_q   [CFG_NUM];
  logic [7:0]         shd_d   [CFG_NUM];
  logic [CFG_NUM-1:0] dirty_q;
  logic [CFG_NUM-1:0] dirty_d;
  logic               commit_s;

  assign commit_s = wr_sel_s & (waddr_s == ADDR_COMMIT);
  assign bad_wr_s = wr_sel_s & ~(|cfg_whit_s) & ~commit_s;

  // Writes land in the shadow; a commit publishes all bytes and strobes the dirty ones.
  always_comb begin
    for (int i = 0; i < CFG_NUM; i++) begin
      shd_d[i]   = (cfg_wr_s & cfg_whit_s[i]) ? fx.fx_data : shd_q[i];
      cfg_q_d[i] = commit_s ? shd_q[i] : cfg_q_q[i];
      view_s[i]  = shd_q[i];
    end
    dirty_d = commit_s ? '0 : (cfg_wr_s ? (dirty_q | cfg_whit_s) : dirty_q);
    wstb_d  = commit_s ? dirty_q : '0;
  end

  // Shadow and dirty state.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CFG_NUM; i++) begin
        shd_q[i] <= cfg_rst_val(CFG_BASE, i);
      end
      dirty_q <= '0;
    end else begin
      shd_q   <= shd_d;
      dirty_q <= dirty_d;
    end
  end
`else
  assign bad_wr_s = wr_sel_s & ~(|cfg_whit_s);

  // Immediate config writes with a matching one-cycle strobe.
  always_comb begin
    for (int i = 0; i < CFG_NUM; i++) begin
      cfg_q_d[i] = (cfg_wr_s & cfg_whit_s[i]) ? fx.fx_data : cfg_q_q[i];
      view_s[i]  = cfg_q_q[i];
    end
    wstb_d = cfg_wr_s ? cfg_whit_s : '0;
  end
`endif

  para_sta_snap #(
    .STA_NUM  (STA_NUM),
    .STA_BASE (STA_BASE)
  ) u_sta_snap (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .rd_sel_i (rd_sel_s),
    .raddr_i  (raddr_s),
    .sta_i    (sta_in),
    .hit_o    (sta_hit_s),
    .rdata_o  (sta_rdata_s)
  );

  // Saturating bad-write counter and read-data mux (reads see pre-write state).
  always_comb begin
    err_d  = bad_wr_s ? ((err_q == 8'hFF) ? 8'hFF : err_q + 8'd1) : err_q;
    fx_q_d = 8'h00;
    if (rd_sel_s) begin
      if (raddr_s == ADDR_ID) begin
        fx_q_d = {2'b00, dev_id};
      end else if (raddr_s == ADDR_VER) begin
        fx_q_d = VERSION;
      end else if (raddr_s == ADDR_ERR) begin
        fx_q_d = err_q;
      end else if (|cfg_rhit_s) begin
        fx_q_d = cfg_rdata_s;
      end else if (sta_hit_s) begin
        fx_q_d = sta_rdata_s;
      end else begin
        fx_q_d = 8'h00;
      end
    end else begin
      fx_q_d = 8'h00;
    end
  end

  // Architectural registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CFG_NUM; i++) begin
        cfg_q_q[i] <= cfg_rst_val(CFG_BASE, i);
      end
      wstb_q <= '0;
      err_q  <= 8'h00;
      fx_q_q <= 8'h00;
    end else begin
      cfg_q_q <= cfg_q_d;
      wstb_q  <= wstb_d;
      err_q   <= err_d;
      fx_q_q  <= fx_q_d;
    end
  end

  for (genvar g = 0; g < CFG_NUM; g++) begin : g_cfg_out
    assign cfg_q[8*g +: 8] = cfg_q_q[g];
  end

  assign cfg_wstb = wstb_q;
  assign err_cnt  = err_q;
  assign fx.fx_q  = fx_q_q;

endmodule
